mem_stage: RTL and testbench

Memory-access pipeline stage between the execute stage and the write-back stage. It registers the execute-stage bus and picks up the synchronous data-SRAM read word that returns one cycle after the execute-stage request. It aligns and sign/zero-extends load data, then hands the final result to write-back under the valid/allowin handshake. It keeps the SRAM read word in a hold register when write-back stalls, and drives the destination/value forwarding outputs used by decode for hazard handling.

---
 rtl/mem_stage_pkg.sv | 21 ++
 rtl/mem_stage_load_align.sv | 41 ++++
 rtl/mem_stage.sv | 100 ++++++++++
 tb/tb_mem_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, load-op bit indices and bus field offsets for the memory stage.
package mem_stage_pkg;

  localparam int unsigned ES_TO_MS = 76;
  localparam int unsigned MS_TO_WS = 70;

  localparam int unsigned LD_B  = 0;
  localparam int unsigned LD_H  = 1;
  localparam int unsigned LD_W  = 2;
  localparam int unsigned LD_BU = 3;
  localparam int unsigned LD_HU = 4;

  // es_to_ms_bus layout: {ld_op, res_from_mem, gr_we, dest, result, pc}
  localparam int unsigned ES_PC_LSB       = 0;
  localparam int unsigned ES_RESULT_LSB   = 32;
  localparam int unsigned ES_DEST_LSB     = 64;
  localparam int unsigned ES_GR_WE_BIT    = 69;
  localparam int unsigned ES_RES_MEM_BIT  = 70;
  localparam int unsigned ES_LD_OP_LSB    = 71;

endpackage

// File: rtl/mem_stage_load_align.sv
// Selects the addressed byte/halfword of a load word and sign- or zero-extends it.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [4:0]  ld_op,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    unique case (off)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    ext_data = '0;
    if (ld_op[LD_B]) begin
      ext_data = {{24{byte_sel[7]}}, byte_sel};
    end else if (ld_op[LD_BU]) begin
      ext_data = {24'd0, byte_sel};
    end else if (ld_op[LD_H]) begin
      ext_data = {{16{half_sel[15]}}, half_sel};
    end else if (ld_op[LD_HU]) begin
      ext_data = {16'd0, half_sel};
    end else if (ld_op[LD_W]) begin
      ext_data = rdata;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the execute bus, aligns load data from the
// synchronous SRAM and holds the returned word while write-back stalls.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                ws_allowin,
  output logic                ms_allowin,
  input  logic                es_to_ms_valid,
  input  logic [ES_TO_MS-1:0] es_to_ms_bus,
  input  logic [31:0]         data_sram_rdata,
  output logic                ms_to_ws_valid,
  output logic [MS_TO_WS-1:0] ms_to_ws_bus,
  output logic [4:0]          ms_to_ds_dest,
  output logic [31:0]         ms_to_ds_value
);

  logic                ms_valid_q, ms_valid_d;
  logic                hold_vld_q, hold_vld_d;
  logic [31:0]         hold_data_q;
  logic [ES_TO_MS-1:0] bus_q;
  logic                ms_ready_go;
  logic                hold_set;

  logic [4:0]  ld_op;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] result;
  logic [31:0] pc;
  logic [31:0] rdata_src;
  logic [31:0] load_data;
  logic [31:0] final_result;
  logic        fwd_en;

  assign ld_op        = bus_q[ES_LD_OP_LSB +: 5];
  assign res_from_mem = bus_q[ES_RES_MEM_BIT];
  assign gr_we        = bus_q[ES_GR_WE_BIT];
  assign dest         = bus_q[ES_DEST_LSB +: 5];
  assign result       = bus_q[ES_RESULT_LSB +: 32];
  assign pc           = bus_q[ES_PC_LSB +: 32];

  assign ms_ready_go    = 1'b1;
  assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid_q && ms_ready_go;

  // Capture only once per stall so the held word stays immutable until consumed.
  assign hold_set = ms_valid_q && !ws_allowin && !hold_vld_q;

  always_comb begin
    ms_valid_d = ms_valid_q;
    if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
    end
    hold_vld_d = hold_vld_q;
    if (ws_allowin) begin
      hold_vld_d = 1'b0;
    end else if (hold_set) begin
      hold_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid_q <= 1'b0;
      hold_vld_q <= 1'b0;
    end else begin
      ms_valid_q <= ms_valid_d;
      hold_vld_q <= hold_vld_d;
    end
  end

  // Data registers carry no reset; they are qualified by ms_valid_q / hold_vld_q.
  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin) begin
      bus_q <= es_to_ms_bus;
    end
    if (hold_set) begin
      hold_data_q <= data_sram_rdata;
    end
  end

  assign rdata_src = hold_vld_q ? hold_data_q : data_sram_rdata;

  load_align u_load_align (
    .rdata    (rdata_src),
    .off      (result[1:0]),
    .ld_op    (ld_op),
    .ext_data (load_data)
  );

  assign final_result = res_from_mem ? load_data : result;
  assign ms_to_ws_bus = {gr_we, dest, final_result, pc};

  assign fwd_en         = ms_valid_q && gr_we;
  assign ms_to_ds_dest  = fwd_en ? dest : 5'd0;
  assign ms_to_ds_value = fwd_en ? final_result : 32'd0;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized and directed bench for mem_stage against a slot-level behavioural model.
module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [75:0] es_to_ms_bus;
  logic [31:0] data_sram_rdata;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [4:0]  ms_to_ds_dest;
  logic [31:0] ms_to_ds_value;

  mem_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .ws_allowin      (ws_allowin),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .data_sram_rdata (data_sram_rdata),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_to_ws_bus    (ms_to_ws_bus),
    .ms_to_ds_dest   (ms_to_ds_dest),
    .ms_to_ds_value  (ms_to_ds_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: the single instruction slot and the word it loaded.
  logic        m_valid;
  logic        m_fixed;
  logic [31:0] m_word;
  logic [75:0] m_bus;
  logic [31:0] pcq[$];
  logic [31:0] next_pc = 32'h1000_0000;

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_align(input logic [31:0] w, input int unsigned off,
                                            input logic [4:0] op);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
    if (op == 5'b00001) return (b >= 128) ? b + 32'hFFFF_FF00 : b;
    if (op == 5'b01000) return b;
    if (op == 5'b00010) return (h >= 32768) ? h + 32'hFFFF_0000 : h;
    if (op == 5'b10000) return h;
    if (op == 5'b00100) return w;
    return 32'd0;
  endfunction

  function automatic logic [75:0] mk_bus(input logic [4:0] op, input logic rfm, input logic we,
                                         input logic [4:0] dst, input logic [31:0] res,
                                         input logic [31:0] pc);
    return {op, rfm, we, dst, res, pc};
  endfunction

  function automatic logic [75:0] new_bus(input logic [4:0] op, input logic rfm, input logic we,
                                          input logic [4:0] dst, input logic [31:0] res);
    next_pc = next_pc + 4;
    return mk_bus(op, rfm, we, dst, res, next_pc);
  endfunction

  task automatic compare();
    logic [31:0] word;
    logic [31:0] fin;
    logic        we;
    chk("valid", {69'd0, ms_to_ws_valid}, {69'd0, m_valid});
    chk("allowin", {69'd0, ms_allowin}, {69'd0, (!m_valid || ws_allowin)});
    if (m_valid) begin
      word = m_fixed ? m_word : data_sram_rdata;
      fin  = m_bus[70] ? ref_align(word, int'(m_bus[33:32]), m_bus[75:71]) : m_bus[63:32];
      we   = m_bus[69];
      chk("ws_bus", ms_to_ws_bus, {we, m_bus[68:64], fin, m_bus[31:0]});
      chk("fwd_dest", {65'd0, ms_to_ds_dest}, {65'd0, (we ? m_bus[68:64] : 5'd0)});
      chk("fwd_value", {38'd0, ms_to_ds_value}, {38'd0, (we ? fin : 32'd0)});
      if (ws_allowin) begin
        if (pcq.size() == 0) begin
          chk("retire_unexpected", {38'd0, ms_to_ws_bus[31:0]}, 70'd0);
        end else begin
          chk("retire_order", {38'd0, ms_to_ws_bus[31:0]}, {38'd0, pcq.pop_front()});
        end
      end
    end else begin
      chk("idle_dest", {65'd0, ms_to_ds_dest}, 70'd0);
      chk("idle_value", {38'd0, ms_to_ds_value}, 70'd0);
    end
  endtask

  // Apply one cycle's inputs and check the DUT at the following negedge.
  task automatic drive(input logic ev, input logic [75:0] bus, input logic ws,
                       input logic [31:0] rd);
    #1;
    es_to_ms_valid  = ev;
    es_to_ms_bus    = bus;
    ws_allowin      = ws;
    data_sram_rdata = rd;
    @(negedge clk);
    compare();
  endtask

  task automatic step();
    logic allow;
    allow = !m_valid || ws_allowin;
    if (m_valid && !m_fixed) begin
      m_word  = data_sram_rdata;
      m_fixed = 1'b1;
    end
    if (allow) begin
      m_valid = es_to_ms_valid;
      m_bus   = es_to_ms_bus;
      m_fixed = 1'b0;
      if (es_to_ms_valid) pcq.push_back(es_to_ms_bus[31:0]);
    end
    @(posedge clk);
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [1:0]  off;
    logic [31:0] rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [75:0] b;
    logic [4:0]  op;
    logic        rfm;
    int          sel;

    vecs[0] = '{5'b00001, 2'd0, 32'h80FF_7F01, 32'h0000_0001};
    vecs[1] = '{5'b00001, 2'd1, 32'h80FF_7F01, 32'h0000_007F};
    vecs[2] = '{5'b00001, 2'd2, 32'h80FF_7F01, 32'hFFFF_FFFF};
    vecs[3] = '{5'b00001, 2'd3, 32'h80FF_7F01, 32'hFFFF_FF80};
    vecs[4] = '{5'b01000, 2'd2, 32'h80FF_7F01, 32'h0000_00FF};
    vecs[5] = '{5'b00010, 2'd0, 32'h8001_7FFE, 32'h0000_7FFE};
    vecs[6] = '{5'b00010, 2'd2, 32'h8001_7FFE, 32'hFFFF_8001};
    vecs[7] = '{5'b10000, 2'd2, 32'h8001_7FFE, 32'h0000_8001};

    m_valid = 1'b0;
    m_fixed = 1'b0;
    m_word  = '0;
    m_bus   = '0;
    resetn = 1'b0;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    ws_allowin = 1'b1;
    data_sram_rdata = '0;

    #12;
    chk("rst_valid", {69'd0, ms_to_ws_valid}, 70'd0);
    chk("rst_allowin", {69'd0, ms_allowin}, 70'd1);
    chk("rst_dest", {65'd0, ms_to_ds_dest}, 70'd0);
    chk("rst_value", {38'd0, ms_to_ds_value}, 70'd0);
    resetn = 1'b1;
    @(posedge clk);

    // ALU pass-through
    drive(1'b1, new_bus(5'd0, 1'b0, 1'b1, 5'd5, 32'h1234_5678), 1'b1, $urandom);
    step();
    drive(1'b0, '0, 1'b1, $urandom);
    chk("alu_result", {38'd0, ms_to_ws_bus[63:32]}, {38'd0, 32'h1234_5678});
    chk("alu_dest", {65'd0, ms_to_ds_dest}, {65'd0, 5'd5});
    step();

    // Byte and halfword alignment table
    foreach (vecs[i]) begin
      drive(1'b1, new_bus(vecs[i].op, 1'b1, 1'b1, 5'd7, {30'h100, vecs[i].off}), 1'b1, $urandom);
      step();
      drive(1'b0, '0, 1'b1, vecs[i].rd);
      chk($sformatf("align%0d", i), {38'd0, ms_to_ws_bus[63:32]}, {38'd0, vecs[i].exp});
      step();
    end

    // Stall hold: word from the first valid cycle survives a changing rdata
    drive(1'b1, new_bus(5'b00100, 1'b1, 1'b1, 5'd9, 32'h200), 1'b1, $urandom);
    step();
    drive(1'b0, '0, 1'b0, 32'hDEAD_BEEF);
    step();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, '0, 1'b0, 32'h0);
      chk("stall_hold", {38'd0, ms_to_ws_bus[63:32]}, {38'd0, 32'hDEAD_BEEF});
      chk("stall_allowin", {69'd0, ms_allowin}, 70'd0);
      step();
    end
    drive(1'b1, new_bus(5'b00100, 1'b1, 1'b1, 5'd9, 32'h204), 1'b1, 32'h0);
    chk("release_hold", {38'd0, ms_to_ws_bus[63:32]}, {38'd0, 32'hDEAD_BEEF});
    step();
    drive(1'b0, '0, 1'b1, 32'h1234_5678);
    chk("hold_cleared", {38'd0, ms_to_ws_bus[63:32]}, {38'd0, 32'h1234_5678});
    step();

    // Back-to-back loads with a stall on the first
    drive(1'b1, new_bus(5'b00100, 1'b1, 1'b1, 5'd3, 32'h300), 1'b1, $urandom);
    step();
    b = new_bus(5'b00100, 1'b1, 1'b1, 5'd4, 32'h304);
    drive(1'b1, b, 1'b0, 32'h11);
    chk("b2b_first", {38'd0, ms_to_ws_bus[63:32]}, {38'd0, 32'h11});
    step();
    drive(1'b1, b, 1'b1, 32'h99);
    chk("b2b_first_held", {38'd0, ms_to_ws_bus[63:32]}, {38'd0, 32'h11});
    step();
    drive(1'b0, '0, 1'b1, 32'h22);
    chk("b2b_second", {38'd0, ms_to_ws_bus[63:32]}, {38'd0, 32'h22});
    step();

    // Reset while valid and stalled
    drive(1'b1, new_bus(5'b00100, 1'b1, 1'b1, 5'd6, 32'h400), 1'b1, $urandom);
    step();
    drive(1'b0, '0, 1'b0, $urandom);
    #1 resetn = 1'b0;
    #1;
    chk("mid_rst_valid", {69'd0, ms_to_ws_valid}, 70'd0);
    chk("mid_rst_allowin", {69'd0, ms_allowin}, 70'd1);
    chk("mid_rst_dest", {65'd0, ms_to_ds_dest}, 70'd0);
    m_valid = 1'b0;
    m_fixed = 1'b0;
    pcq.delete();
    @(posedge clk);
    #2 resetn = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 5);
      op  = (sel == 5) ? 5'd0 : 5'(1 << sel);
      rfm = (sel != 5);
      drive(($urandom_range(0, 9) < 7), new_bus(op, rfm, 1'($urandom), 5'($urandom),
            $urandom), ($urandom_range(0, 9) < 6), $urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
